fpadd_arbiter: RTL and testbench
================================

Name: fpadd_arbiter

Overview:
- Shares one fpadd_pipelined instance between two independent requesters (0 and 1).
- Round-robin grant, with valid/ready handshake on the request side.
- A tag delay line matched to the adder latency routes each sum back to its originator as a one-cycle response pulse.
- Sits between test/stimulus sources (operand sequencers, UART/switch front-ends) and the adder in fpadd_system; also exposes a completion count for the LEDs.

Parameters:
- WIDTH, 32, operand/result width (IEEE-754 single).
- LATENCY, 3, clock edges from operands applied on add_a/add_b to the sum valid on add_result. Must match fpadd_pipelined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  grant enable; 0 blocks new grants, in-flight ops still complete
- req0_valid  in  1  requester 0 has operands
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- resp0_valid  out  1  one-cycle pulse: result for requester 0
- resp1_valid  out  1  one-cycle pulse: result for requester 1
- resp_result  out  WIDTH  sum; qualified by resp0_valid or resp1_valid
- add_a  out  WIDTH  operand A to fpadd_pipelined
- add_b  out  WIDTH  operand B to fpadd_pipelined
- add_result  in  WIDTH  sum from fpadd_pipelined
- done_count  out  8  completed operations, wraps 255->0, drives leds

Behaviour:
- Reset (sync, rst=1 at edge): add_a=0, add_b=0, resp0_valid=0, resp1_valid=0, resp_result=0, done_count=0, priority pointer prio=0, all tag valids cleared.
- Grant logic is combinational:
  - req0_ready = en & req0_valid & (!req1_valid | prio==0)
  - req1_ready = en & req1_valid & (!req0_valid | prio==1)
  - At most one ready is high. Ready is never asserted while rst=1.
- Handshake: valid&ready sampled at edge E0. At E0:
  - add_a/add_b register the granted operands.
  - Tag {1, id} enters stage 0 of the tag delay line.
  - prio <= other id, only when both requesters were valid; otherwise prio is unchanged.
- No grant at an edge: add_a/add_b hold their values; a tag {0, x} enters the delay line.
- Tag delay line depth LATENCY+1 (registered). At E0+LATENCY+1:
  - resp_result <= add_result.
  - resp{id}_valid <= 1 for exactly one cycle.
  - done_count increments.
- Latency: fixed LATENCY+1 edges from handshake to the response pulse. Throughput is one op per cycle. Back-to-back grants produce back-to-back responses in grant order.
- Requester must hold a/b stable while valid is high and not ready (not checked).
- No response backpressure: responses cannot stall. A requester that cannot sink a result loses it.
- Both responses are never high in the same cycle.
- Responses are emitted while en=0; en only gates new grants.
- rst mid-operation: all in-flight tags are dropped, so no response appears for ops granted before reset. done_count returns to 0.
- done_count at 255 plus a completion -> 0.

Decomposition:
- Shared package fpadd_pkg:
  - FP_WIDTH=32 and FPADD_LATENCY=3, both shared with fpadd_pipelined.
  - Requester-id encoding (REQ0=0, REQ1=1).
  - Tag struct {valid, id}.
- One natural sub-module: fpadd_tag_pipe.
  - Parameterised-depth shift register of tags with synchronous clear.
  - Reused later by the multiplier arbiter.
- Grant/prio logic and output registers stay in fpadd_arbiter.
- The bench instantiates the real fpadd_pipelined on add_a/add_b/add_result.

Test Plan:
- Single op: req0 {6b64b235, 6ac49214} for one handshake -> after 4 edges, resp0_valid=1 for one cycle, resp_result=6ba37d9f, resp1_valid=0, done_count=1.
- Contention: both valid continuously from reset, req0 {3f800000, 3f800000}, req1 {40000000, 3f800000} -> grants alternate 0,1,0,1. Responses alternate with 40000000 (resp0) and 40400000 (resp1), one per cycle, never both valid.
- Single requester streaming: req1 valid for 10 cycles, req0 idle -> req1_ready high every cycle, 10 consecutive resp1 pulses, prio unchanged at 0.
- en gating: ops in flight, en dropped -> no ready while en=0; in-flight responses still arrive; granting resumes the cycle en returns to 1.
- Reset mid-flight: grant 2 ops, assert rst one cycle later -> no responses ever appear for them; done_count=0; add_a=add_b=0.
- Wrap: 256 completed ops -> done_count reads 0 after the 256th response.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared constants and types for the floating-point adder and its request arbiter.
package fpadd_pkg;

  localparam int FP_WIDTH      = 32;
  localparam int FPADD_LATENCY = 3;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/fpadd_arbiter_if.sv
// Requester-side bus of the adder arbiter: two request channels and a shared response.
interface fpadd_arbiter_if
  import fpadd_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             resp0_valid;
  logic             resp1_valid;
  logic [WIDTH-1:0] resp_result;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_result
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_result
  );

endinterface

// File: rtl/fpadd_pipelined.sv
// Three-stage single-precision adder (align, add, normalise), truncating, denormals flushed to zero.
module fpadd_pipelined
  import fpadd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [FP_WIDTH-1:0] a,
  input  logic [FP_WIDTH-1:0] b,
  output logic [FP_WIDTH-1:0] result
);

  logic        a_big;
  logic [7:0]  exp_small;
  logic [7:0]  exp_diff;
  logic [23:0] man_small;
  logic [4:0]  shamt;
  logic [53:0] small_shift;
  logic        s1_sign_reg, s1_sub_reg;
  logic [7:0]  s1_exp_reg;
  logic [26:0] s1_big_reg, s1_small_reg;
  logic        s2_sign_reg;
  logic [7:0]  s2_exp_reg;
  logic [27:0] s2_sum_reg;
  logic [4:0]  lz;
  logic [31:0] result_next, result_reg;

  assign a_big       = a[30:0] >= b[30:0];
  assign exp_small   = a_big ? b[30:23] : a[30:23];
  assign man_small   = a_big ? {|b[30:23], b[22:0]} : {|a[30:23], a[22:0]};
  assign exp_diff    = (a_big ? a[30:23] : b[30:23]) - exp_small;
  assign shamt       = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
  // Three guard bits plus a sticky bit keep the truncated result exact for subtraction too
  assign small_shift = {man_small, 30'd0} >> shamt;

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (s2_sum_reg[i]) lz = 5'(26 - i);
    end
    result_next = 32'd0;
    if (s2_sum_reg[27]) begin
      if (s2_exp_reg >= 8'd254) result_next = {s2_sign_reg, 8'hFF, 23'd0};
      else result_next = {s2_sign_reg, s2_exp_reg + 8'd1, s2_sum_reg[26:4]};
    end else if (s2_sum_reg[26:0] != 27'd0 && {3'b000, lz} < s2_exp_reg) begin
      result_next = {s2_sign_reg, s2_exp_reg - {3'b000, lz},
                     23'((s2_sum_reg[25:0] << lz) >> 3)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_reg  <= 1'b0;
      s1_sub_reg   <= 1'b0;
      s1_exp_reg   <= '0;
      s1_big_reg   <= '0;
      s1_small_reg <= '0;
      s2_sign_reg  <= 1'b0;
      s2_exp_reg   <= '0;
      s2_sum_reg   <= '0;
      result_reg   <= '0;
    end else begin
      s1_sign_reg  <= a_big ? a[31] : b[31];
      s1_sub_reg   <= a[31] ^ b[31];
      s1_exp_reg   <= a_big ? a[30:23] : b[30:23];
      s1_big_reg   <= a_big ? {|a[30:23], a[22:0], 3'b000} : {|b[30:23], b[22:0], 3'b000};
      s1_small_reg <= {small_shift[53:28], small_shift[27] | (|small_shift[26:0])};
      s2_sign_reg  <= s1_sign_reg;
      s2_exp_reg   <= s1_exp_reg;
      s2_sum_reg   <= s1_sub_reg ? {1'b0, s1_big_reg} - {1'b0, s1_small_reg}
                                 : {1'b0, s1_big_reg} + {1'b0, s1_small_reg};
      result_reg   <= result_next;
    end
  end

  assign result = result_reg;

endmodule

// File: rtl/fpadd_tag_pipe.sv
// Fixed-depth shift register of {valid, id} tags with synchronous clear.
module fpadd_tag_pipe
  import fpadd_pkg::*;
#(
  parameter int DEPTH = FPADD_LATENCY + 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    tag_t q_reg;
    tag_t q_next;

    if (gi == 0) begin : g_head
      assign q_next = tag_in;
    end else begin : g_tail
      assign q_next = g_stage[gi-1].q_reg;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q_reg <= '0;
      end else begin
        q_reg <= q_next;
      end
    end
  end

  assign tag_out = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin sharing of one pipelined adder between two requesters; a matched
// tag line steers each sum back to its originator as a one-cycle pulse.
module fpadd_arbiter
  import fpadd_pkg::*;
#(
  parameter int WIDTH   = FP_WIDTH,
  parameter int LATENCY = FPADD_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  fpadd_arbiter_if.slave   bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_result,
  output logic [7:0]       done_count
);

  req_id_t          prio_reg;
  logic             grant0, grant1, both_valid;
  tag_t             tag_in, tag_out;
  logic [WIDTH-1:0] add_a_reg, add_b_reg, resp_result_reg;
  logic             resp0_reg, resp1_reg;
  logic [7:0]       done_count_reg;

  assign both_valid = bus.req0_valid & bus.req1_valid;
  assign grant0 = !rst & en & bus.req0_valid & (!bus.req1_valid | (prio_reg == REQ0));
  assign grant1 = !rst & en & bus.req1_valid & (!bus.req0_valid | (prio_reg == REQ1));
  assign tag_in = '{valid: grant0 | grant1, id: grant1 ? REQ1 : REQ0};

  // One extra stage beyond the adder latency lines the tag up with the registered response
  fpadd_tag_pipe #(.DEPTH(LATENCY + 1)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_reg       <= '0;
      add_b_reg       <= '0;
      prio_reg        <= REQ0;
      resp0_reg       <= 1'b0;
      resp1_reg       <= 1'b0;
      resp_result_reg <= '0;
      done_count_reg  <= '0;
    end else begin
      if (grant0) begin
        add_a_reg <= bus.req0_a;
        add_b_reg <= bus.req0_b;
      end else if (grant1) begin
        add_a_reg <= bus.req1_a;
        add_b_reg <= bus.req1_b;
      end
      if (both_valid && (grant0 || grant1)) prio_reg <= grant0 ? REQ1 : REQ0;
      resp0_reg <= tag_out.valid && (tag_out.id == REQ0);
      resp1_reg <= tag_out.valid && (tag_out.id == REQ1);
      if (tag_out.valid) begin
        resp_result_reg <= add_result;
        done_count_reg  <= done_count_reg + 8'd1;
      end
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = resp0_reg;
  assign bus.resp1_valid = resp1_reg;
  assign bus.resp_result = resp_result_reg;
  assign add_a           = add_a_reg;
  assign add_b           = add_b_reg;
  assign done_count      = done_count_reg;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Scenario bench for fpadd_arbiter driving the real pipelined adder; a scoreboard
// queue per requester holds the expected sum and arrival cycle of every grant.
module tb_fpadd_arbiter;
  import fpadd_pkg::*;

  localparam int W   = FP_WIDTH;
  localparam int LAT = FPADD_LATENCY;

  typedef struct {
    logic [W-1:0] value;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] add_a, add_b, add_result;
  logic [7:0]   done_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp0_cnt = 0;
  int resp1_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  logic [W-1:0] op0_sum, op1_sum;

  fpadd_arbiter_if #(.WIDTH(W)) bus ();

  fpadd_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .done_count (done_count)
  );

  fpadd_pipelined u_add (
    .clk    (clk),
    .rst    (rst),
    .a      (add_a),
    .b      (add_b),
    .result (add_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes push expectations; responses pop and compare value and arrival cycle
  always @(negedge clk) begin
    if (bus.req0_valid === 1'b1 && bus.req0_ready === 1'b1) begin
      mon_e.value = op0_sum; mon_e.due = cyc + LAT + 2; q0.push_back(mon_e);
    end
    if (bus.req1_valid === 1'b1 && bus.req1_ready === 1'b1) begin
      mon_e.value = op1_sum; mon_e.due = cyc + LAT + 2; q1.push_back(mon_e);
    end
    if (bus.resp0_valid === 1'b1 || bus.resp1_valid === 1'b1) begin
      total++;
      if (bus.resp0_valid === 1'b1 && bus.resp1_valid === 1'b1) begin
        bad++;
        $display("FAIL resp_exclusive: got resp0_valid=1 resp1_valid=1, required at most one");
      end
    end
    if (bus.resp0_valid === 1'b1) begin
      resp0_cnt++; total++;
      $display("resp0 cyc=%0d result=%h", cyc, bus.resp_result);
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL resp0_unexpected: got result %h at cyc %0d, required no response", bus.resp_result, cyc);
      end else begin
        mon_e = q0.pop_front();
        if (bus.resp_result !== mon_e.value || cyc != mon_e.due) begin
          bad++;
          $display("FAIL resp0_scoreboard: got %h at cyc %0d, required %h at cyc %0d", bus.resp_result, cyc, mon_e.value, mon_e.due);
        end
      end
    end
    if (bus.resp1_valid === 1'b1) begin
      resp1_cnt++; total++;
      $display("resp1 cyc=%0d result=%h", cyc, bus.resp_result);
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL resp1_unexpected: got result %h at cyc %0d, required no response", bus.resp_result, cyc);
      end else begin
        mon_e = q1.pop_front();
        if (bus.resp_result !== mon_e.value || cyc != mon_e.due) begin
          bad++;
          $display("FAIL resp1_scoreboard: got %h at cyc %0d, required %h at cyc %0d", bus.resp_result, cyc, mon_e.value, mon_e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    bus.req0_a = 32'h3f800000; bus.req0_b = 32'h3f800000; op0_sum = 32'h40000000;
    bus.req1_a = 32'h40000000; bus.req1_b = 32'h3f800000; op1_sum = 32'h40400000;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    step(); step();
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got ready0=%b ready1=%b, required 0 0", bus.req0_ready, bus.req1_ready);
    end
    total++;
    if (add_a !== '0 || add_b !== '0) begin
      bad++;
      $display("FAIL reset_add_ops: got %h %h, required 0 0", add_a, add_b);
    end
    total++;
    if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0 || bus.resp_result !== '0) begin
      bad++;
      $display("FAIL reset_resp: got %b %b %h, required 0 0 0", bus.resp0_valid, bus.resp1_valid, bus.resp_result);
    end
    total++;
    if (done_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_done_count: got %0d, required 0", done_count);
    end
    step();
    rst = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_single_op();
    step();
    bus.req0_a = 32'h6b64b235; bus.req0_b = 32'h6ac49214; op0_sum = 32'h6ba37d9f;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready: got %b, required 1", bus.req0_ready);
    end
    step();
    bus.req0_valid = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (bus.resp0_valid !== 1'(k == 4)) begin
        bad++;
        $display("FAIL single_pulse: edge %0d got resp0_valid=%b, required %b", k, bus.resp0_valid, 1'(k == 4));
      end
      if (k == 4) begin
        total++;
        if (bus.resp_result !== 32'h6ba37d9f || bus.resp1_valid !== 1'b0 || done_count !== 8'd1) begin
          bad++;
          $display("FAIL single_result: got %h resp1=%b count=%0d, required 6ba37d9f 0 1", bus.resp_result, bus.resp1_valid, done_count);
        end
      end
    end
  endtask

  task automatic test_contention();
    int n0, n1;
    n0 = resp0_cnt; n1 = resp1_cnt;
    step();
    rst = 1'b1;
    bus.req0_a = 32'h3f800000; bus.req0_b = 32'h3f800000; op0_sum = 32'h40000000;
    bus.req1_a = 32'h40000000; bus.req1_b = 32'h3f800000; op1_sum = 32'h40400000;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (bus.req0_ready !== 1'(k % 2 == 0) || bus.req1_ready !== 1'(k % 2 == 1)) begin
        bad++;
        $display("FAIL contention_grant: slot %0d got ready0=%b ready1=%b, required %b %b", k, bus.req0_ready, bus.req1_ready, 1'(k % 2 == 0), 1'(k % 2 == 1));
      end
      step();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (8) step();
    @(negedge clk);
    total++;
    if (resp0_cnt - n0 != 4 || resp1_cnt - n1 != 4 || q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL contention_count: got resp0=%0d resp1=%0d pending=%0d, required 4 4 0", resp0_cnt - n0, resp1_cnt - n1, q0.size() + q1.size());
    end
    total++;
    if (done_count !== 8'd8) begin
      bad++;
      $display("FAIL contention_done_count: got %0d, required 8", done_count);
    end
  endtask

  task automatic test_streaming();
    int first, last, n;
    first = -1; last = -1; n = 0;
    step();
    bus.req1_a = 32'h40000000; bus.req1_b = 32'h3f800000; op1_sum = 32'h40400000;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 10) begin
        total++;
        if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
          bad++;
          $display("FAIL stream_ready: cycle %0d got ready1=%b ready0=%b, required 1 0", k, bus.req1_ready, bus.req0_ready);
        end
      end
      if (bus.resp1_valid === 1'b1) begin
        n++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      step();
      if (k == 9) bus.req1_valid = 1'b0;
    end
    total++;
    if (n != 10 || last - first != 9) begin
      bad++;
      $display("FAIL stream_pulses: got %0d pulses over %0d cycles, required 10 over 10", n, last - first + 1);
    end
    bus.req0_a = 32'h3f800000; bus.req0_b = 32'h3f800000; op0_sum = 32'h40000000;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL stream_prio_kept: got ready0=%b ready1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
      bad++;
      $display("FAIL stream_prio_turn: got ready0=%b ready1=%b, required 0 1", bus.req0_ready, bus.req1_ready);
    end
    step();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_en_gating();
    int n0;
    bus.req0_a = 32'h3f800000; bus.req0_b = 32'h3f800000; op0_sum = 32'h40000000;
    bus.req0_valid = 1'b1; en = 1'b1;
    repeat (2) step();
    en = 1'b0; bus.req1_valid = 1'b1;
    n0 = resp0_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        bad++;
        $display("FAIL en_block: cycle %0d got ready0=%b ready1=%b, required 0 0", k, bus.req0_ready, bus.req1_ready);
      end
      step();
    end
    total++;
    if (resp0_cnt - n0 != 2) begin
      bad++;
      $display("FAIL en_inflight: got %0d responses while en=0, required 2", resp0_cnt - n0);
    end
    en = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL en_resume: got ready0=%b ready1=%b, required 1 0", bus.req0_ready, bus.req1_ready);
    end
    step();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (6) step();
    @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL en_drain: got %0d pending, required 0", q0.size() + q1.size());
    end
  endtask

  task automatic test_reset_midflight();
    int n0, n1;
    step();
    bus.req0_a = 32'h3f800000; bus.req0_b = 32'h3f800000; op0_sum = 32'h40000000;
    bus.req0_valid = 1'b1;
    step(); step();
    bus.req0_valid = 1'b0; rst = 1'b1;
    q0.delete(); q1.delete();
    n0 = resp0_cnt; n1 = resp1_cnt;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (done_count !== 8'd0 || add_a !== '0 || add_b !== '0) begin
      bad++;
      $display("FAIL midreset_state: got count=%0d a=%h b=%h, required 0 0 0", done_count, add_a, add_b);
    end
    repeat (8) step();
    @(negedge clk);
    total++;
    if (resp0_cnt != n0 || resp1_cnt != n1 || done_count !== 8'd0) begin
      bad++;
      $display("FAIL midreset_dropped: got %0d responses count=%0d, required 0 0", resp0_cnt - n0 + resp1_cnt - n1, done_count);
    end
  endtask

  task automatic test_wrap();
    step();
    bus.req0_a = 32'h3f800000; bus.req0_b = 32'h3f800000; op0_sum = 32'h40000000;
    bus.req0_valid = 1'b1;
    repeat (255) step();
    bus.req0_valid = 1'b0;
    repeat (6) step();
    @(negedge clk);
    total++;
    if (done_count !== 8'd255) begin
      bad++;
      $display("FAIL wrap_255: got %0d, required 255", done_count);
    end
    step();
    bus.req0_valid = 1'b1;
    step();
    bus.req0_valid = 1'b0;
    repeat (6) step();
    @(negedge clk);
    total++;
    if (done_count !== 8'd0 || q0.size() != 0) begin
      bad++;
      $display("FAIL wrap_zero: got count=%0d pending=%0d, required 0 0", done_count, q0.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    op0_sum = '0; op1_sum = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_streaming();
    test_en_gating();
    test_reset_midflight();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
